// File: rtl/ext_irq_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ext_irq_controller_pkg
//  Description : Shared encodings and default sizing for the external
//                interrupt controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package ext_irq_controller_pkg;

    // Default sizing: ID width must equal clog2 of the line count
    localparam int DEF_N_IRQ = 8;
    localparam int DEF_ID_W  = 3;

    // Handshake state encoding, 2 bits
    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

endpackage : ext_irq_controller_pkg
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : irq_prio_enc
//  Description : Combinational fixed-priority encoder, lowest index wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_enc #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = 3
) (
    input  logic [N_IRQ-1:0] req_vec,
    output logic             any,
    output logic [ID_W-1:0]  idx
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                any = 1'b1;
                idx = ID_W'(i);
            end
        end
    end

endmodule : irq_prio_enc
`default_nettype wire

// File: rtl/ext_irq_controller.sv
`default_nettype none
// ============================================================================
//  Module      : ext_irq_controller
//  Description : Synchronises N external interrupt pins, captures rising edges
//                as pending bits, selects one enabled line by fixed priority
//                and presents it to the core via an irq/ack/eoi handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module ext_irq_controller
    import ext_irq_controller_pkg::*;
#(
    parameter int N_IRQ = DEF_N_IRQ,
    parameter int ID_W  = DEF_ID_W
) (
    input  logic             gclk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [N_IRQ-1:0] irq_en,
    output logic             irq,
    output logic [ID_W-1:0]  irq_id,
    input  logic             irq_ack,
    input  logic             irq_eoi,
    output logic             in_service,
    output logic [N_IRQ-1:0] pending
);

    logic [N_IRQ-1:0] sync1_q;
    logic [N_IRQ-1:0] sync2_q;
    logic [N_IRQ-1:0] hist_q;
    logic [N_IRQ-1:0] edge_w;

    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] clr_w;
    logic             irq_q, irq_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;
    logic             in_service_q, in_service_d;
    irq_state_e       state_q, state_d;

    logic             sel_any_w;
    logic [ID_W-1:0]  sel_idx_w;

    // Two-flop synchroniser plus a history flop for rising-edge detection
    always_ff @(posedge gclk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            hist_q  <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign edge_w = sync2_q & ~hist_q;

    // Only enabled pending lines compete; masked lines still accumulate
    irq_prio_enc #(
        .N_IRQ (N_IRQ),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .req_vec (pending_q & irq_en),
        .any     (sel_any_w),
        .idx     (sel_idx_w)
    );

    // Handshake next-state and pending update; a new edge beats a same-cycle clear
    always_comb begin
        state_d      = state_q;
        irq_d        = irq_q;
        irq_id_d     = irq_id_q;
        in_service_d = in_service_q;
        clr_w        = '0;

        case (state_q)
            IRQ_IDLE: begin
                if (sel_any_w) begin
                    irq_id_d = sel_idx_w;
                    irq_d    = 1'b1;
                    state_d  = IRQ_REQ;
                end
            end
            IRQ_REQ: begin
                // irq_id is frozen here: no preemption, enable changes ignored
                if (irq_ack) begin
                    clr_w[irq_id_q] = 1'b1;
                    irq_d           = 1'b0;
                    in_service_d    = 1'b1;
                    state_d         = IRQ_SERVICE;
                end
            end
            IRQ_SERVICE: begin
                if (irq_eoi) begin
                    in_service_d = 1'b0;
                    state_d      = IRQ_IDLE;
                end
            end
            default: begin
                irq_d        = 1'b0;
                in_service_d = 1'b0;
                state_d      = IRQ_IDLE;
            end
        endcase

        pending_d = (pending_q & ~clr_w) | edge_w;
    end

    // Handshake and pending state registers
    always_ff @(posedge gclk or negedge rst) begin
        if (!rst) begin
            state_q      <= IRQ_IDLE;
            irq_q        <= 1'b0;
            irq_id_q     <= '0;
            in_service_q <= 1'b0;
            pending_q    <= '0;
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_d;
            irq_id_q     <= irq_id_d;
            in_service_q <= in_service_d;
            pending_q    <= pending_d;
        end
    end

    assign irq        = irq_q;
    assign irq_id     = irq_id_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;

endmodule : ext_irq_controller
`default_nettype wire
